// File: rtl/cpu_defs.sv
// cpu_defs: definitions shared across the custom_cpu front end.
//   - default reset PC and sequential PC increment
//   - one-hot state encoding of the instruction fetch unit FSM
//   - word-alignment helper for fetch addresses
package cpu_defs;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_STEP_DEFAULT  = 32'd4;

    // One-hot so each state bit is its own flop and drives outputs directly.
    typedef enum logic [3:0] {
        S_INIT = 4'b0001,
        S_REQ  = 4'b0010,
        S_WAIT = 4'b0100,
        S_HOLD = 4'b1000
    } ifu_state_e;

    // Fetches are always 4-byte aligned; the low two address bits are dropped.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: instruction fetch front end, sits upstream of the I-cache.
// Owns the PC, issues one aligned fetch per instruction, captures the returned
// word and hands it to decode. Redirects are accepted in every state and any
// response belonging to the wrong path is discarded.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   to_icache_req_valid/addr  fetch request to the cache (addr[1:0] == 0)
//   from_icache_req_ready     cache accepts the request
//   from_icache_rsp_valid/data cache response (instruction word)
//   to_icache_rsp_ready       IFU accepts the response
//   redirect_valid/pc         one-cycle redirect pulse and target
//   to_id_valid/inst/pc       instruction and its PC presented to decode
//   from_id_ready             decode accepts the instruction
//
// All outputs come straight from flops (state bits, PC, FPC, IR).
module inst_fetch_unit
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        to_icache_req_valid,
    output logic [31:0] to_icache_req_addr,
    input  logic        from_icache_req_ready,
    input  logic        from_icache_rsp_valid,
    input  logic [31:0] from_icache_rsp_data,
    output logic        to_icache_rsp_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        to_id_valid,
    output logic [31:0] to_id_inst,
    output logic [31:0] to_id_pc,
    input  logic        from_id_ready
);

    ifu_state_e  state_q, state_d;
    logic [31:0] pc_q, pc_d;        // next address to fetch (kept aligned)
    logic [31:0] fpc_q, fpc_d;      // address of the request in flight / held
    logic [31:0] ir_q, ir_d;        // captured instruction
    logic        discard_q, discard_d;

    logic        req_fire_s;
    logic [31:0] redirect_pc_s;

    assign req_fire_s    = (state_q == S_REQ) && from_icache_req_ready;
    assign redirect_pc_s = align_word(redirect_pc);

    // Next-state logic: redirect is checked first in every state so it wins.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        fpc_d     = fpc_q;
        ir_d      = ir_q;
        discard_d = discard_q;
        unique case (state_q)
            S_INIT: begin
                state_d = S_REQ;
                if (redirect_valid) begin
                    pc_d = redirect_pc_s;
                end else begin
                    pc_d = pc_q;
                end
            end
            S_REQ: begin
                if (req_fire_s) begin
                    fpc_d   = pc_q;
                    state_d = S_WAIT;
                    if (redirect_valid) begin
                        // Request already accepted: its response is wrong-path.
                        pc_d      = redirect_pc_s;
                        discard_d = 1'b1;
                    end else begin
                        discard_d = discard_q;
                    end
                end else if (redirect_valid) begin
                    pc_d = redirect_pc_s;
                end else begin
                    pc_d = pc_q;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc_s;
                    if (from_icache_rsp_valid) begin
                        // The outstanding response is consumed now, so nothing
                        // is left in flight to discard.
                        discard_d = 1'b0;
                        state_d   = S_REQ;
                    end else begin
                        discard_d = 1'b1;
                    end
                end else if (from_icache_rsp_valid) begin
                    if (discard_q) begin
                        discard_d = 1'b0;
                        state_d   = S_REQ;
                    end else begin
                        ir_d    = from_icache_rsp_data;
                        state_d = S_HOLD;
                    end
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    // Decode flushes itself on redirect; a same-cycle accept is ignored.
                    pc_d    = redirect_pc_s;
                    ir_d    = 32'h0000_0000;
                    state_d = S_REQ;
                end else if (from_id_ready) begin
                    pc_d    = fpc_q + PC_STEP;
                    state_d = S_REQ;
                end else begin
                    state_d = S_HOLD;
                end
            end
            default: begin
                // Illegal one-hot value: restart cleanly.
                state_d   = S_INIT;
                discard_d = 1'b0;
            end
        endcase
    end

    // State, PC and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_INIT;
            pc_q      <= align_word(RESET_PC);
            fpc_q     <= 32'h0000_0000;
            ir_q      <= 32'h0000_0000;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            fpc_q     <= fpc_d;
            ir_q      <= ir_d;
            discard_q <= discard_d;
        end
    end

    assign to_icache_req_valid = (state_q == S_REQ);
    assign to_icache_req_addr  = pc_q;
    assign to_icache_rsp_ready = (state_q == S_WAIT);
    assign to_id_valid         = (state_q == S_HOLD);
    assign to_id_inst          = ir_q;
    assign to_id_pc            = fpc_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed testbench for inst_fetch_unit with a small I-cache responder model.
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        to_icache_req_valid;
    logic [31:0] to_icache_req_addr;
    logic        from_icache_req_ready;
    logic        from_icache_rsp_valid;
    logic [31:0] from_icache_rsp_data;
    logic        to_icache_rsp_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        to_id_valid;
    logic [31:0] to_id_inst;
    logic [31:0] to_id_pc;
    logic        from_id_ready;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;

    // Cache model controls
    int          lat    = 1;
    logic        ovr_en = 1'b0;
    logic [31:0] ovr_data = 32'hDEAD_BEEF;
    int          cnt    = 0;
    logic [31:0] pend_data = 32'h0000_0000;
    logic        bad_seen = 1'b0;

    inst_fetch_unit dut (
        .clk                  (clk),
        .rst                  (rst),
        .to_icache_req_valid  (to_icache_req_valid),
        .to_icache_req_addr   (to_icache_req_addr),
        .from_icache_req_ready(from_icache_req_ready),
        .from_icache_rsp_valid(from_icache_rsp_valid),
        .from_icache_rsp_data (from_icache_rsp_data),
        .to_icache_rsp_ready  (to_icache_rsp_ready),
        .redirect_valid       (redirect_valid),
        .redirect_pc          (redirect_pc),
        .to_id_valid          (to_id_valid),
        .to_id_inst           (to_id_inst),
        .to_id_pc             (to_id_pc),
        .from_id_ready        (from_id_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // Cache: response appears lat cycles after the handshake cycle, one-cycle pulse.
    always @(negedge clk) begin
        if (rst) begin
            cnt                   <= 0;
            from_icache_rsp_valid <= 1'b0;
            from_icache_rsp_data  <= 32'h0000_0000;
        end else begin
            from_icache_rsp_valid <= 1'b0;
            if (cnt != 0) begin
                cnt <= cnt - 1;
                if (cnt == 1) begin
                    from_icache_rsp_valid <= 1'b1;
                    from_icache_rsp_data  <= pend_data;
                end
            end
            if (to_icache_req_valid && from_icache_req_ready) begin
                cnt       <= lat;
                pend_data <= ovr_en ? ovr_data : mem(to_icache_req_addr);
            end
        end
    end

    // Watch for the poisoned word ever reaching decode.
    always @(posedge clk) begin
        if (to_id_valid && to_id_inst == 32'hDEAD_BEEF) bad_seen <= 1'b1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_req();
        int k = 0;
        while (to_icache_req_valid !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        chk("wait_req", {31'd0, to_icache_req_valid}, 32'd1);
    endtask

    task automatic wait_id();
        int k = 0;
        while (to_id_valid !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        chk("wait_id", {31'd0, to_id_valid}, 32'd1);
    endtask

    initial begin
        int last_cyc;
        rst                   = 1'b1;
        from_icache_req_ready = 1'b1;
        redirect_valid        = 1'b0;
        redirect_pc           = 32'h0000_0000;
        from_id_ready         = 1'b1;

        // Reset state
        step();
        step();
        chk("rst_req_valid", {31'd0, to_icache_req_valid}, 32'd0);
        chk("rst_rsp_ready", {31'd0, to_icache_rsp_ready}, 32'd0);
        chk("rst_id_valid", {31'd0, to_id_valid}, 32'd0);
        chk("rst_inst", to_id_inst, 32'h0);
        rst = 1'b0;
        // S_INIT cycle: still nothing asserted
        chk("init_req_valid", {31'd0, to_icache_req_valid}, 32'd0);
        step();
        chk("first_req_valid", {31'd0, to_icache_req_valid}, 32'd1);

        // Steady flow: 0x0, 0x4, 0x8, one every 3 cycles
        last_cyc = 0;
        for (int i = 0; i < 3; i++) begin
            wait_req();
            chk("seq_addr", to_icache_req_addr, 32'(4 * i));
            wait_id();
            chk("seq_pc", to_id_pc, 32'(4 * i));
            chk("seq_inst", to_id_inst, mem(32'(4 * i)));
            if (i > 0) chk("seq_period", 32'(cyc - last_cyc), 32'd3);
            last_cyc = cyc;
            if (i < 2) step();
        end

        // Decode backpressure for 5 cycles while holding 0x8
        from_id_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", {31'd0, to_id_valid}, 32'd1);
            chk("bp_pc", to_id_pc, 32'h8);
            chk("bp_inst", to_id_inst, mem(32'h8));
            chk("bp_no_req", {31'd0, to_icache_req_valid}, 32'd0);
        end
        from_id_ready = 1'b1;
        step();
        chk("bp_next_addr", to_icache_req_addr, 32'hC);
        chk("bp_next_valid", {31'd0, to_icache_req_valid}, 32'd1);

        // Redirect in S_WAIT; poisoned response arrives 3 cycles after handshake
        lat    = 3;
        ovr_en = 1'b1;
        step();
        chk("wait_rsp_ready", {31'd0, to_icache_rsp_ready}, 32'd1);
        chk("wait_no_req", {31'd0, to_icache_req_valid}, 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        step();
        redirect_valid = 1'b0;
        wait_req();
        ovr_en = 1'b0;
        lat    = 1;
        chk("rw_addr", to_icache_req_addr, 32'h100);
        wait_id();
        chk("rw_pc", to_id_pc, 32'h100);
        chk("rw_inst", to_id_inst, mem(32'h100));
        chk("rw_no_beef", {31'd0, bad_seen}, 32'd0);

        // Redirect in S_HOLD with decode ready in the same cycle
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        step();
        redirect_valid = 1'b0;
        chk("rh_id_valid", {31'd0, to_id_valid}, 32'd0);
        chk("rh_req_valid", {31'd0, to_icache_req_valid}, 32'd1);
        chk("rh_addr", to_icache_req_addr, 32'h200);
        wait_id();
        chk("rh_pc", to_id_pc, 32'h200);
        chk("rh_inst", to_id_inst, mem(32'h200));

        // Redirect in the same cycle as rsp_valid
        step();
        chk("rr_pre_addr", to_icache_req_addr, 32'h204);
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        step();
        redirect_valid = 1'b0;
        chk("rr_id_valid", {31'd0, to_id_valid}, 32'd0);
        chk("rr_req_valid", {31'd0, to_icache_req_valid}, 32'd1);
        chk("rr_addr", to_icache_req_addr, 32'h300);
        wait_id();
        chk("rr_pc", to_id_pc, 32'h300);
        chk("rr_inst", to_id_inst, mem(32'h300));

        // Redirect in the same cycle as the request handshake
        step();
        chk("rq_pre_addr", to_icache_req_addr, 32'h304);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        step();
        redirect_valid = 1'b0;
        chk("rq_rsp_ready", {31'd0, to_icache_rsp_ready}, 32'd1);
        step();
        chk("rq_id_valid", {31'd0, to_id_valid}, 32'd0);
        chk("rq_req_valid", {31'd0, to_icache_req_valid}, 32'd1);
        chk("rq_addr", to_icache_req_addr, 32'h300);
        wait_id();
        chk("rq_pc", to_id_pc, 32'h300);
        chk("rq_inst", to_id_inst, mem(32'h300));

        // Redirect in S_REQ without handshake, unaligned target near the top
        step();
        from_icache_req_ready = 1'b0;
        redirect_valid        = 1'b1;
        redirect_pc           = 32'hFFFF_FFFE;
        step();
        redirect_valid = 1'b0;
        chk("wr_req_valid", {31'd0, to_icache_req_valid}, 32'd1);
        chk("wr_addr", to_icache_req_addr, 32'hFFFF_FFFC);
        from_icache_req_ready = 1'b1;
        wait_id();
        chk("wr_pc", to_id_pc, 32'hFFFF_FFFC);
        chk("wr_inst", to_id_inst, mem(32'hFFFF_FFFC));
        step();
        chk("wrap_addr", to_icache_req_addr, 32'h0000_0000);
        chk("wrap_valid", {31'd0, to_icache_req_valid}, 32'd1);

        // Reset in the middle of S_WAIT
        lat = 3;
        step();
        chk("mr_rsp_ready", {31'd0, to_icache_rsp_ready}, 32'd1);
        rst = 1'b1;
        step();
        chk("mr_req_valid", {31'd0, to_icache_req_valid}, 32'd0);
        chk("mr_rsp_ready0", {31'd0, to_icache_rsp_ready}, 32'd0);
        chk("mr_id_valid", {31'd0, to_id_valid}, 32'd0);
        chk("mr_addr", to_icache_req_addr, 32'h0);
        chk("mr_inst", to_id_inst, 32'h0);
        chk("mr_pc", to_id_pc, 32'h0);
        rst = 1'b0;
        lat = 1;
        step();
        chk("mr_init_addr", to_icache_req_addr, 32'h0);
        chk("mr_init_valid", {31'd0, to_icache_req_valid}, 32'd1);
        wait_id();
        chk("mr_pc_after", to_id_pc, 32'h0);
        chk("mr_inst_after", to_id_inst, mem(32'h0));
        chk("final_no_beef", {31'd0, bad_seen}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
